regfile_write_arbiter: RTL

- Shares the single register-file write port (RegWrite / writereg / writedata, 32 x 64-bit RegFile) among NUM_REQ write-back requesters, e.g. ALU, load unit and multiplier.
- Round-robin arbitration with a valid/ready handshake per requester.
- Optional lock lets one requester keep the port for back-to-back beats.
- One registered output stage drives the RegFile write inputs directly.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_write_arbiter_rr_pick.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-file write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam int ZERO_REG   = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Round-robin first-set finder: first request at or above start, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan N positions beginning at start; the first requester seen wins.
    always_comb begin
        int p;
        p   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            p = (int'(start) + k) % N;
            if (!any && req[p]) begin
                any    = 1'b1;
                gnt[p] = 1'b1;
                idx    = IW'(p);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the RegFile write port, with optional grant lock.
// Latency: a beat accepted in cycle N drives RegWrite/writereg/writedata in N+1.
// Backpressure: one-hot req_ready, all zero under hold; REGFILE_WRITE_ARBITER_FWD_EN adds bypass ports.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        hold,
    output logic                        RegWrite,
    output logic [ADDR_W-1:0]           writereg,
    output logic [DATA_W-1:0]           writedata,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
`ifdef REGFILE_WRITE_ARBITER_FWD_EN
    ,
    input  logic [ADDR_W-1:0]           fwd_raddr1,
    input  logic [ADDR_W-1:0]           fwd_raddr2,
    output logic                        fwd_hit1,
    output logic                        fwd_hit2,
    output logic [DATA_W-1:0]           fwd_data1,
    output logic [DATA_W-1:0]           fwd_data2
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    arb_state_e        state_q, state_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] writereg_q, writereg_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] ready;
    logic               xfer;
    logic [IDW-1:0]     win_idx;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .req   (req_valid),
        .start (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Select this cycle's winner: round-robin pick when idle, only the owner when locked.
    always_comb begin
        ready   = '0;
        xfer    = 1'b0;
        win_idx = pick_idx;
        if (!hold) begin
            if (state_q == IDLE) begin
                ready = pick_gnt;
                xfer  = pick_any;
            end else begin
                win_idx        = owner_q;
                xfer           = req_valid[owner_q];
                ready[owner_q] = req_valid[owner_q];
            end
        end
        win_addr = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        win_data = req_data[int'(win_idx)*DATA_W +: DATA_W];
    end

    // Lock FSM and pointer; the pointer only moves on grants won from IDLE.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            case (state_q)
                IDLE: begin
                    rr_ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
                    if (req_lock[win_idx]) begin
                        state_d = LOCKED;
                        owner_d = win_idx;
                    end
                end
                LOCKED: begin
                    if (!req_lock[owner_q]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output stage: writes to the zero register are accepted but never enabled.
    always_comb begin
        regwrite_d  = xfer && (win_addr != ZERO_ADDR);
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
        grant_id_d  = grant_id_q;
        if (xfer) begin
            writereg_d  = win_addr;
            writedata_d = win_data;
            grant_id_d  = win_idx;
        end
    end

    // State and output registers; reset clears RegWrite without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
            grant_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign req_ready = ready;
    assign RegWrite  = regwrite_q;
    assign writereg  = writereg_q;
    assign writedata = writedata_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == LOCKED);

`ifdef REGFILE_WRITE_ARBITER_FWD_EN
    // Same-cycle bypass of the write currently presented to the RegFile.
    always_comb begin
        fwd_hit1  = regwrite_q && (fwd_raddr1 != ZERO_ADDR) && (writereg_q == fwd_raddr1);
        fwd_hit2  = regwrite_q && (fwd_raddr2 != ZERO_ADDR) && (writereg_q == fwd_raddr2);
        fwd_data1 = fwd_hit1 ? writedata_q : '0;
        fwd_data2 = fwd_hit2 ? writedata_q : '0;
    end
`endif

endmodule
